// File: rtl/lsu_dbus_ctrl.sv
// Load/store controller between the execute stage and the byte-banked data bus.
// Turns one byte/half/word access into a single-cycle bus request with byte
// lanes and replicated store data, waits for the ack (or a timeout), and
// returns sign/zero-extended load data with a one-cycle done pulse.
module lsu_dbus_ctrl #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            lsu_req,
  input  logic            lsu_we,
  input  logic [1:0]      lsu_size,
  input  logic            lsu_unsigned,
  input  logic [XLEN-1:0] lsu_addr,
  input  logic [XLEN-1:0] lsu_wdata,
  output logic            lsu_done,
  output logic            lsu_err,
  output logic [XLEN-1:0] lsu_rdata,
  output logic            lsu_stall,
  output logic            dbus_req,
  output logic            dbus_we,
  output logic [XLEN-1:0] dbus_addr,
  output logic [XLEN-1:0] dbus_wdata,
  output logic [3:0]      dbus_sel_byte,
  input  logic [XLEN-1:0] dbus_rdata,
  input  logic            dbus_ack
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t          state_r, state_nxt_s;
  logic            we_r;
  logic [1:0]      size_r;
  logic            uns_r;
  logic [XLEN-1:0] addr_r;
  logic [XLEN-1:0] wdata_r;
  logic            err_r;
  logic [XLEN-1:0] rdata_r;
  logic [CW-1:0]   cnt_r;
  logic [CW-1:0]   cnt_inc_s;
  logic            timeout_hit_s;
  logic            misaligned_s;

  // Size 11 is illegal; halves need an even address, words a 4-byte aligned one.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return off[0];
      2'b10:   return |off;
      default: return 1'b1;
    endcase
  endfunction

  // Byte lanes touched by the access within the addressed word.
  function automatic logic [3:0] lane_sel(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << {off[1], 1'b0};
      2'b10:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Store data replicated across lanes so any selected lane carries the right bytes.
  function automatic logic [XLEN-1:0] lane_wdata(input logic [1:0] size, input logic [XLEN-1:0] w);
    case (size)
      2'b00:   return {(XLEN/8){w[7:0]}};
      2'b01:   return {(XLEN/16){w[15:0]}};
      default: return w;
    endcase
  endfunction

  // Right-align the addressed bytes of the bus word and extend to XLEN.
  function automatic logic [XLEN-1:0] load_extract(input logic [XLEN-1:0] word,
                                                   input logic [1:0] size,
                                                   input logic uns,
                                                   input logic [1:0] off);
    logic [XLEN-1:0] sh;
    sh = word >> {off, 3'b000};
    case (size)
      2'b00:   return {{(XLEN-8){~uns & sh[7]}}, sh[7:0]};
      2'b01:   return {{(XLEN-16){~uns & sh[15]}}, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  assign misaligned_s  = is_misaligned(lsu_size, lsu_addr[1:0]);
  assign cnt_inc_s     = cnt_r + {{(CW-1){1'b0}}, 1'b1};
  assign timeout_hit_s = (cnt_inc_s == CW'(TIMEOUT_CYCLES - 1));
  assign lsu_stall     = lsu_req & ~lsu_done;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; ack is only looked at in WAIT so stale acks are dropped.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (lsu_req) begin
          state_nxt_s = misaligned_s ? S_RESP : S_REQ;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_REQ:  state_nxt_s = S_WAIT;
      S_WAIT: begin
        if (dbus_ack || timeout_hit_s) begin
          state_nxt_s = S_RESP;
        end else begin
          state_nxt_s = S_WAIT;
        end
      end
      S_RESP:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Operand capture, timeout counter, error flag and load-data latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_r    <= 1'b0;
      size_r  <= 2'b00;
      uns_r   <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
      err_r   <= 1'b0;
      rdata_r <= '0;
      cnt_r   <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (lsu_req) begin
            we_r    <= lsu_we;
            size_r  <= lsu_size;
            uns_r   <= lsu_unsigned;
            addr_r  <= lsu_addr;
            wdata_r <= lsu_wdata;
            err_r   <= misaligned_s;
            rdata_r <= '0;
          end
        end
        S_REQ: cnt_r <= '0;
        S_WAIT: begin
          cnt_r <= cnt_inc_s;
          if (dbus_ack) begin
            rdata_r <= we_r ? '0 : load_extract(dbus_rdata, size_r, uns_r, addr_r[1:0]);
          end else if (timeout_hit_s) begin
            err_r <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode from the registered state and captured operands.
  always_comb begin
    lsu_done      = 1'b0;
    lsu_err       = 1'b0;
    lsu_rdata     = '0;
    dbus_req      = 1'b0;
    dbus_we       = 1'b0;
    dbus_addr     = '0;
    dbus_wdata    = '0;
    dbus_sel_byte = 4'b0000;
    case (state_r)
      S_REQ, S_WAIT: begin
        dbus_req      = (state_r == S_REQ);
        dbus_we       = we_r;
        dbus_addr     = {addr_r[XLEN-1:2], 2'b00};
        dbus_wdata    = lane_wdata(size_r, wdata_r);
        dbus_sel_byte = lane_sel(size_r, addr_r[1:0]);
      end
      S_RESP: begin
        lsu_done  = 1'b1;
        lsu_err   = err_r;
        lsu_rdata = rdata_r;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_dbus_ctrl.sv
// Self-checking bench for lsu_dbus_ctrl: directed vector table, hand-written
// timeout/reset sequences, and random accesses against a byte-level model.
module tb_lsu_dbus_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lsu_req, lsu_we, lsu_unsigned;
  logic [1:0]  lsu_size;
  logic [31:0] lsu_addr, lsu_wdata;
  logic        lsu_done, lsu_err, lsu_stall;
  logic [31:0] lsu_rdata;
  logic        dbus_req, dbus_we, dbus_ack;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic [3:0]  dbus_sel_byte;

  int checks = 0;
  int errors = 0;

  lsu_dbus_ctrl #(.XLEN(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_size(lsu_size), .lsu_unsigned(lsu_unsigned),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_done(lsu_done), .lsu_err(lsu_err), .lsu_rdata(lsu_rdata), .lsu_stall(lsu_stall),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata),
    .dbus_sel_byte(dbus_sel_byte), .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack)
  );

  always #5 clk = ~clk;

  // Results observed by do_access.
  int          o_done_k, o_ndone, o_nreq;
  logic        o_err, o_we, o_stall;
  logic [31:0] o_rdata, o_addr, o_wdata;
  logic [3:0]  o_sel;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem;
    int          delay;
    logic        e_err;
    int          e_done;
    int          e_nreq;
    logic [3:0]  e_sel;
    logic [31:0] e_dw;
    logic [31:0] e_rd;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Run one access starting now (just after a posedge). The bus acks `delay`
  // cycles after it sees dbus_req (delay>15 means never). Watches 3 cycles past done.
  task automatic do_access(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] mem, input int delay, input bit drop);
    int k, req_k, tail;
    bit seen;
    k = 0; req_k = 0; tail = -1; seen = 1'b0;
    o_done_k = -1; o_ndone = 0; o_nreq = 0; o_err = 1'b0; o_rdata = '0;
    o_addr = '0; o_wdata = '0; o_sel = 4'b0000; o_we = 1'b0; o_stall = 1'b1;
    lsu_req = 1'b1; lsu_we = we; lsu_size = size; lsu_unsigned = uns;
    lsu_addr = addr; lsu_wdata = wdata;
    while (k < 60 && (tail < 0 || k < tail)) begin
      dbus_ack   = seen && (k == req_k + delay);
      dbus_rdata = dbus_ack ? mem : $urandom;
      @(negedge clk);
      if (dbus_req) begin
        o_nreq++;
        if (!seen) begin
          seen = 1'b1; req_k = k;
          o_addr = dbus_addr; o_wdata = dbus_wdata; o_sel = dbus_sel_byte; o_we = dbus_we;
        end
      end
      if (lsu_done) begin
        o_ndone++;
        if (o_ndone == 1) begin
          o_done_k = k; o_err = lsu_err; o_rdata = lsu_rdata; o_stall = lsu_stall; tail = k + 4;
        end
      end
      @(posedge clk); #1;
      k++;
      if (drop || tail >= 0) lsu_req = 1'b0;
    end
    lsu_req = 1'b0;
    dbus_ack = 1'b0;
  endtask

  // Byte-level reference: lanes, replication and extension computed per byte.
  task automatic model(input vec_t v, output vec_t r);
    int nb, off;
    logic [31:0] val, msk;
    r = v;
    off = int'(v.addr[1:0]);
    nb = (v.size == 2'd0) ? 1 : (v.size == 2'd1) ? 2 : (v.size == 2'd2) ? 4 : 0;
    r.e_sel = 4'b0000; r.e_dw = '0; r.e_rd = '0;
    if (nb == 0 || (off % nb) != 0) begin
      r.e_err = 1'b1; r.e_done = 1; r.e_nreq = 0;
    end else begin
      r.e_nreq = 1;
      for (int b = 0; b < 4; b++) begin
        r.e_sel[b] = (b >= off) && (b < off + nb);
        r.e_dw[8*b +: 8] = v.wdata[8*(b % nb) +: 8];
      end
      if (v.delay > 15) begin
        r.e_err = 1'b1; r.e_done = 17;
      end else begin
        r.e_err = 1'b0; r.e_done = 2 + v.delay;
        if (!v.we) begin
          val = '0;
          for (int i = 0; i < nb; i++) val[8*i +: 8] = v.mem[8*(off+i) +: 8];
          if (!v.uns && nb < 4 && val[8*nb-1]) begin
            msk = (32'd1 << (8*nb)) - 32'd1;
            val = val | ~msk;
          end
          r.e_rd = val;
        end
      end
    end
  endtask

  task automatic check_access(input vec_t e, input logic [31:0] addr);
    chk("done_cycle", o_done_k, e.e_done);
    chk("done_count", o_ndone, 32'd1);
    chk("err", {31'd0, o_err}, {31'd0, e.e_err});
    chk("rdata", o_rdata, e.e_rd);
    chk("stall_at_done", {31'd0, o_stall}, 32'd0);
    chk("req_count", o_nreq, e.e_nreq);
    if (e.e_nreq == 1) begin
      chk("sel_byte", {28'd0, o_sel}, {28'd0, e.e_sel});
      chk("bus_wdata", o_wdata, e.e_dw);
      chk("bus_addr", o_addr, {addr[31:2], 2'b00});
      chk("bus_we", {31'd0, o_we}, {31'd0, e.we});
    end
  endtask

  vec_t tbl[$];
  vec_t v, r;
  int   nd;

  initial begin
    // we size uns addr wdata mem delay | err done nreq sel dw rdata
    tbl.push_back('{1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80FF_1234, 1, 1'b0, 3, 1, 4'b1000, 32'h0, 32'hFFFF_FF80});
    tbl.push_back('{1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 32'h80FF_1234, 1, 1'b0, 3, 1, 4'b1100, 32'h0, 32'h0000_80FF});
    tbl.push_back('{1'b1, 2'd0, 1'b0, 32'h201, 32'hAB, 32'h0, 2, 1'b0, 4, 1, 4'b0010, 32'hABAB_ABAB, 32'h0});
    tbl.push_back('{1'b1, 2'd2, 1'b0, 32'h202, 32'h5555_AAAA, 32'h0, 2, 1'b1, 1, 0, 4'b0000, 32'h0, 32'h0});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 32'hDEAD_BEEF, 1, 1'b0, 3, 1, 4'b1111, 32'h0, 32'hDEAD_BEEF});
    tbl.push_back('{1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 32'h80FF_1234, 1, 1'b0, 3, 1, 4'b1100, 32'h0, 32'hFFFF_80FF});
    tbl.push_back('{1'b0, 2'd1, 1'b0, 32'h100, 32'h0, 32'h80FF_1234, 1, 1'b0, 3, 1, 4'b0011, 32'h0, 32'h0000_1234});
    tbl.push_back('{1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80FF_1234, 1, 1'b0, 3, 1, 4'b1000, 32'h0, 32'h0000_0080});
    tbl.push_back('{1'b0, 2'd3, 1'b0, 32'h300, 32'h0, 32'h1, 1, 1'b1, 1, 0, 4'b0000, 32'h0, 32'h0});
    tbl.push_back('{1'b1, 2'd1, 1'b0, 32'h302, 32'h1234_5678, 32'h0, 2, 1'b0, 4, 1, 4'b1100, 32'h5678_5678, 32'h0});
    tbl.push_back('{1'b0, 2'd1, 1'b0, 32'h101, 32'h0, 32'h0, 1, 1'b1, 1, 0, 4'b0000, 32'h0, 32'h0});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h104, 32'h0, 32'h0BAD_F00D, 15, 1'b0, 17, 1, 4'b1111, 32'h0, 32'h0BAD_F00D});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h108, 32'h0, 32'h0, 255, 1'b1, 17, 1, 4'b1111, 32'h0, 32'h0});

    rst_n = 1'b0; lsu_req = 1'b0; lsu_we = 1'b0; lsu_size = 2'd0; lsu_unsigned = 1'b0;
    lsu_addr = '0; lsu_wdata = '0; dbus_rdata = '0; dbus_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_done", {31'd0, lsu_done}, 32'd0);
    chk("reset_dbus_req", {31'd0, dbus_req}, 32'd0);
    chk("reset_sel", {28'd0, dbus_sel_byte}, 32'd0);
    chk("reset_rdata", lsu_rdata, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table.
    foreach (tbl[i]) begin
      do_access(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata,
                tbl[i].mem, tbl[i].delay, 1'b0);
      check_access(tbl[i], tbl[i].addr);
    end

    // lsu_req dropped right after acceptance still completes once.
    v = '{1'b0, 2'd0, 1'b0, 32'h501, 32'h0, 32'h0000_7F00, 1, 1'b0, 3, 1, 4'b0010, 32'h0, 32'h0000_007F};
    do_access(v.we, v.size, v.uns, v.addr, v.wdata, v.mem, v.delay, 1'b1);
    check_access(v, v.addr);

    // Reset while waiting on the bus, then a stale ack: no completion may appear.
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_size = 2'd2; lsu_unsigned = 1'b0;
    lsu_addr = 32'h400; lsu_wdata = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0; lsu_req = 1'b0;
    #1;
    chk("rst_mid_dbus_req", {31'd0, dbus_req}, 32'd0);
    chk("rst_mid_sel", {28'd0, dbus_sel_byte}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; dbus_ack = 1'b1; dbus_rdata = 32'hCAFE_0001;
    nd = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (lsu_done) nd++;
      @(posedge clk); #1;
      dbus_ack = 1'b0;
    end
    chk("stale_ack_done", nd, 32'd0);
    v = '{1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 32'h1122_3344, 1, 1'b0, 3, 1, 4'b1111, 32'h0, 32'h1122_3344};
    do_access(v.we, v.size, v.uns, v.addr, v.wdata, v.mem, v.delay, 1'b0);
    check_access(v, v.addr);

    // Random accesses against the byte-level model.
    for (int n = 0; n < 150; n++) begin
      v.we    = 1'($urandom_range(0, 1));
      v.size  = 2'($urandom_range(0, 3));
      v.uns   = 1'($urandom_range(0, 1));
      v.addr  = $urandom;
      v.wdata = $urandom;
      v.mem   = $urandom;
      v.delay = ($urandom_range(0, 19) == 0) ? 255 : int'($urandom_range(1, 4));
      model(v, r);
      do_access(v.we, v.size, v.uns, v.addr, v.wdata, v.mem, v.delay, 1'($urandom_range(0, 1)));
      check_access(r, v.addr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
